// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions: field widths, canned special encodings and the
// sequencing states used by the iterative divider.
package bf16_pkg;

   localparam int EXP_W    = 8;
   localparam int FRAC_W   = 7;
   localparam int EXP_BIAS = 127;

   localparam logic [15:0] QNAN    = 16'h7FC0;
   localparam logic [15:0] POS_INF = 16'h7F80;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DIV   = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/bf16_div_seq_if.sv
// Start/done request bundle for the iterative bf16 divider.
interface bf16_div_seq_if;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        busy;
   logic        done;
   logic [15:0] C;

   modport master (output start, A, B, input busy, done, C);
   modport slave  (input start, A, B, output busy, done, C);
endinterface

// File: rtl/bf16_classify.sv
// Combinational bf16 operand decode; denormals are flushed to zero so the
// significand always carries an explicit hidden one for nonzero operands.
module bf16_classify
   import bf16_pkg::*;
(
   input  logic [15:0]       op,
   output logic              sign,
   output logic              is_zero,
   output logic              is_inf,
   output logic              is_nan,
   output logic [EXP_W-1:0]  exponent,
   output logic [FRAC_W:0]   significand
);

   always_comb begin
      sign        = op[15];
      exponent    = op[14:7];
      is_zero     = (exponent == '0);
      is_inf      = (&exponent) && (op[6:0] == '0);
      is_nan      = (&exponent) && (op[6:0] != '0);
      significand = is_zero ? '0 : {1'b1, op[6:0]};
   end

endmodule

// File: rtl/bf16_div_seq.sv
// Iterative bf16 divider: radix-2 restoring mantissa divide, one bit per cycle,
// followed by a single normalize/round cycle. Latency is fixed at 11 edges.
module bf16_div_seq
   import bf16_pkg::*;
#(
   parameter int QUOT_BITS = 10   // datapath slicing below assumes exactly 10
) (
   input  logic          clk,
   input  logic          rst,
   bf16_div_seq_if.slave io
);

   state_t               state_q, state_d;
   logic [15:0]          a_q, a_d, b_q, b_d, c_q, c_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [8:0]           rem_q, rem_d;
   logic [QUOT_BITS-1:0] quo_q, quo_d;
   logic                 busy_q, busy_d, done_q, done_d;

   logic                 sa, sb, za, zb, ia, ib, na, nb;
   logic [EXP_W-1:0]     ea, eb;
   logic [FRAC_W:0]      ma, mb;

   bf16_classify u_cls_a (.op(a_q), .sign(sa), .is_zero(za), .is_inf(ia),
                          .is_nan(na), .exponent(ea), .significand(ma));
   bf16_classify u_cls_b (.op(b_q), .sign(sb), .is_zero(zb), .is_inf(ib),
                          .is_nan(nb), .exponent(eb), .significand(mb));

   // First DIV cycle seeds the remainder with the dividend significand.
   logic [8:0] rem_cur;
   logic [7:0] rem_sub;
   logic       q_bit;

   always_comb begin
      rem_cur = (cnt_q == 4'd0) ? {1'b0, ma} : rem_q;
      q_bit   = (rem_cur >= {1'b0, mb});
      rem_sub = q_bit ? 8'(rem_cur - {1'b0, mb}) : rem_cur[7:0];
   end

   logic              s_res, guard, sticky, rnd;
   logic signed [9:0] exp_raw, exp_norm, exp_fin;
   logic [8:0]        qn;
   logic [7:0]        frac_rnd;
   logic [15:0]       res;

   always_comb begin
      s_res   = sa ^ sb;
      exp_raw = {2'b00, ea} - {2'b00, eb} + 10'(EXP_BIAS);
      // qn holds the bits below the leading one after normalization.
      if (quo_q[QUOT_BITS-1]) begin
         qn       = quo_q[8:0];
         exp_norm = exp_raw;
      end else begin
         qn       = {quo_q[7:0], 1'b0};
         exp_norm = exp_raw - 10'sd1;
      end
      guard    = qn[1];
      sticky   = qn[0] | (|rem_q);
      rnd      = guard & (sticky | qn[2]);
      frac_rnd = {1'b0, qn[8:2]} + {7'd0, rnd};
      exp_fin  = exp_norm + {9'd0, frac_rnd[7]};

      if (na || nb || (za && zb) || (ia && ib))
         res = QNAN;
      else if (zb || ia)
         res = POS_INF | {s_res, 15'd0};
      else if (za || ib)
         res = {s_res, 15'd0};
      else if (exp_fin >= 10'sd255)
         res = POS_INF | {s_res, 15'd0};
      else if (exp_fin <= 10'sd0)
         res = {s_res, 15'd0};
      else
         res = {s_res, exp_fin[7:0], frac_rnd[6:0]};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
            if (io.start) begin
               state_d = DIV;
               a_d     = io.A;
               b_d     = io.B;
               cnt_d   = '0;
               rem_d   = '0;
               quo_d   = '0;
               busy_d  = 1'b1;
            end
         end
         DIV: begin
            rem_d = {rem_sub, 1'b0};
            quo_d = {quo_q[QUOT_BITS-2:0], q_bit};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(QUOT_BITS - 1)) state_d = ROUND;
         end
         ROUND: begin
            c_d     = res;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign io.busy = busy_q;
   assign io.done = done_q;
   assign io.C    = c_q;

endmodule

// File: tb/tb_bf16_div_seq.sv
// Scoreboard bench for bf16_div_seq: expected quotients are queued at issue and
// popped when done is seen; inputs driven on negedge, outputs sampled on negedge.
module tb_bf16_div_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [15:0] sb[$];
   logic [15:0] last_c = 16'h0000;

   bf16_div_seq_if dif();

   bf16_div_seq #(.QUOT_BITS(10)) dut (.clk(clk), .rst(rst), .io(dif));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
      @(negedge clk);
      dif.start = 1'b1; dif.A = a; dif.B = b;
      sb.push_back(e);
      @(negedge clk);
      dif.start = 1'b0; dif.A = 16'($urandom); dif.B = 16'($urandom);
   endtask

   // Called at the first negedge after the accepting edge (lat = 0).
   task automatic wait_done(output int lat, output bit busy_ok);
      lat = 0; busy_ok = 1'b1;
      while (!dif.done && lat < 30) begin
         if (dif.busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk); lat++;
      end
      if (dif.busy !== 1'b0) busy_ok = 1'b0;
   endtask

   task automatic test_reset;
      dif.start = 1'b1; dif.A = 16'h4040; dif.B = 16'h4000; rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", dif.busy); end
      checks++; if (dif.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", dif.done); end
      checks++; if (dif.C !== 16'h0000) begin failures++; $display("FAIL reset_c got=%h want=0000", dif.C); end
      dif.start = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", dif.busy); end
   endtask

   task automatic run_table(input string tag, input logic [15:0] av[], input logic [15:0] bv[], input logic [15:0] ev[]);
      int lat; bit bok; logic [15:0] e;
      for (int i = 0; i < av.size(); i++) begin
         drive_op(av[i], bv[i], ev[i]);
         wait_done(lat, bok);
         e = 16'hxxxx;
         if (sb.size() != 0) e = sb.pop_front();
         last_c = e;
         checks++; if (lat !== 11) begin failures++; $display("FAIL %s_latency[%0d] got=%0d want=11", tag, i, lat); end
         checks++; if (!bok) begin failures++; $display("FAIL %s_busy[%0d] got=bad want=high_for_cycles_1_11", tag, i); end
         checks++; if (dif.C !== e) begin failures++; $display("FAIL %s_c[%0d] A=%h B=%h got=%h want=%h", tag, i, av[i], bv[i], dif.C, e); end
         @(negedge clk);
         checks++; if (dif.done !== 1'b0) begin failures++; $display("FAIL %s_done_pulse[%0d] got=%b want=0", tag, i, dif.done); end
      end
   endtask

   task automatic test_normal;
      logic [15:0] av[] = '{16'h4040, 16'h3F80, 16'h40C0, 16'hBF80, 16'h3F80};
      logic [15:0] bv[] = '{16'h4000, 16'h4040, 16'hC000, 16'hBF80, 16'h3F81};
      logic [15:0] ev[] = '{16'h3FC0, 16'h3EAB, 16'hC040, 16'h3F80, 16'h3F7E};
      run_table("normal", av, bv, ev);
   endtask

   task automatic test_specials;
      logic [15:0] av[] = '{16'h3F80, 16'h0000, 16'h7F80, 16'h0000, 16'h7FC1, 16'h7F80,
                            16'h4000, 16'h0001, 16'hFF80, 16'h3F80, 16'h4000, 16'h3F80};
      logic [15:0] bv[] = '{16'h0000, 16'h0000, 16'h7F80, 16'hBF80, 16'h3F80, 16'h4000,
                            16'h7F80, 16'h3F80, 16'h4000, 16'h8000, 16'h0001, 16'hFFC0};
      logic [15:0] ev[] = '{16'h7F80, 16'h7FC0, 16'h7FC0, 16'h8000, 16'h7FC0, 16'h7F80,
                            16'h0000, 16'h0000, 16'hFF80, 16'hFF80, 16'h7F80, 16'h7FC0};
      run_table("special", av, bv, ev);
   endtask

   task automatic test_range;
      logic [15:0] av[] = '{16'h7F7F, 16'h0080, 16'h7F00, 16'h0100, 16'h0080, 16'hFF7F};
      logic [15:0] bv[] = '{16'h3F00, 16'h4000, 16'h3F80, 16'h4000, 16'h3F81, 16'h3F00};
      logic [15:0] ev[] = '{16'h7F80, 16'h0000, 16'h7F00, 16'h0080, 16'h0000, 16'hFF80};
      run_table("range", av, bv, ev);
   endtask

   task automatic test_back_to_back;
      logic [15:0] av[] = '{16'h4040, 16'h3F80, 16'h7F80, 16'h40C0};
      logic [15:0] bv[] = '{16'h4000, 16'h4040, 16'h4000, 16'hC000};
      logic [15:0] ev[] = '{16'h3FC0, 16'h3EAB, 16'h7F80, 16'hC040};
      int last_cyc = 0; int t; logic [15:0] e;
      @(negedge clk);
      dif.start = 1'b1; dif.A = av[0]; dif.B = bv[0]; sb.push_back(ev[0]);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i < 3) begin
            dif.A = av[i+1]; dif.B = bv[i+1]; sb.push_back(ev[i+1]);
         end else dif.start = 1'b0;
         t = 0;
         while (!dif.done && t < 30) begin @(negedge clk); t++; end
         checks++; if (dif.done !== 1'b1) begin failures++; $display("FAIL b2b_timeout[%0d] got=no_done want=done", i); end
         e = 16'hxxxx;
         if (sb.size() != 0) e = sb.pop_front();
         last_c = e;
         checks++; if (dif.C !== e) begin failures++; $display("FAIL b2b_c[%0d] got=%h want=%h", i, dif.C, e); end
         if (i > 0) begin
            checks++; if (cyc - last_cyc !== 12) begin failures++; $display("FAIL b2b_period[%0d] got=%0d want=12", i, cyc - last_cyc); end
         end
         last_cyc = cyc;
      end
      @(negedge clk);
   endtask

   task automatic test_busy_ignore;
      int t; logic [15:0] e; logic [15:0] prev;
      prev = last_c;
      drive_op(16'h4040, 16'h4000, 16'h3FC0);
      repeat (3) @(negedge clk);
      checks++; if (dif.C !== prev) begin failures++; $display("FAIL busy_c_hold got=%h want=%h", dif.C, prev); end
      dif.start = 1'b1; dif.A = 16'h3F80; dif.B = 16'h4040;
      @(negedge clk);
      dif.start = 1'b0;
      t = 0;
      while (!dif.done && t < 30) begin @(negedge clk); t++; end
      e = 16'hxxxx;
      if (sb.size() != 0) e = sb.pop_front();
      last_c = e;
      checks++; if (dif.done !== 1'b1) begin failures++; $display("FAIL busy_timeout got=no_done want=done"); end
      checks++; if (dif.C !== e) begin failures++; $display("FAIL busy_ignore_c got=%h want=%h", dif.C, e); end
      t = 0;
      repeat (15) begin @(negedge clk); if (dif.done === 1'b1 || dif.busy === 1'b1) t++; end
      checks++; if (t !== 0) begin failures++; $display("FAIL busy_ignore_extra got=%0d_active_cycles want=0", t); end
      checks++; if (dif.C !== e) begin failures++; $display("FAIL busy_ignore_c_hold got=%h want=%h", dif.C, e); end
   endtask

   task automatic test_reset_mid;
      int t;
      logic [15:0] av[] = '{16'h40C0};
      logic [15:0] bv[] = '{16'hC000};
      logic [15:0] ev[] = '{16'hC040};
      drive_op(16'h3F80, 16'h4040, 16'h3EAB);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", dif.busy); end
      checks++; if (dif.done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b want=0", dif.done); end
      checks++; if (dif.C !== 16'h0000) begin failures++; $display("FAIL midrst_c got=%h want=0000", dif.C); end
      sb.delete();
      last_c = 16'h0000;
      @(negedge clk);
      rst = 1'b0;
      t = 0;
      repeat (15) begin @(negedge clk); if (dif.done === 1'b1) t++; end
      checks++; if (t !== 0) begin failures++; $display("FAIL midrst_stray_done got=%0d want=0", t); end
      run_table("after_rst", av, bv, ev);
   endtask

   initial begin
      dif.start = 1'b0; dif.A = '0; dif.B = '0;
      test_reset();
      test_normal();
      test_specials();
      test_range();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bf16_div_seq.md
Name: bf16_div_seq

Overview:
- Iterative bfloat16 divider (C = A / B): the inverse operation of the combinational bf16 multiplier in the FPU.
- Format: 1 sign, 8 exponent (bias 127), 7 fraction bits.
- Uses a start/done handshake with fixed latency, so the FPU sequencer and the directed-vector bench can drive it the same way for every operand pair.
- Radix-2 restoring mantissa division followed by one normalize/round cycle.

Parameters:
- QUOT_BITS, 10, quotient bits generated: 1 integer bit, 7 fraction bits, guard bit, extra bit. Sticky is taken from the remainder. Only the value 10 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE or DONE.
- A  in  16  dividend, bf16. Captured on the accepting edge.
- B  in  16  divisor, bf16. Captured on the accepting edge.
- busy  out  1  high in DIV and ROUND.
- done  out  1  one-cycle pulse: C is valid.
- C  out  16  quotient, bf16. Held until the next result is written.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, C=16'h0000, all internal registers cleared. Reset mid-operation abandons the division; no done is produced.
- States:
  - IDLE: start=1 captures A and B, moves to DIV, iteration counter = 0.
  - DIV: one quotient bit per cycle for QUOT_BITS cycles, then ROUND.
  - ROUND: registers C, moves to DONE.
  - DONE: done=1 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- start while busy=1 is ignored. A and B may change freely after the accepting edge.
- Latency:
  - Accepting edge k → DIV occupies edges k+1..k+10 → ROUND.
  - Edge k+11 writes C and raises done. done drops at edge k+12.
  - Latency is fixed for all inputs, including special cases.
- Classification:
  - Exponent 0 means zero; nonzero fraction with exponent 0 (denormal) is flushed to zero.
  - Exponent 255 with fraction 0 is inf; exponent 255 with nonzero fraction is NaN.
- Special results (priority order; sign = sA xor sB except for NaN):
  - any NaN, 0/0, or inf/inf → 16'h7FC0
  - x/0 → signed inf {s, 8'hFF, 7'h0}
  - inf/x → signed inf
  - 0/x or x/inf → signed zero
  - Special results still traverse DIV/ROUND; the divide datapath runs, but its output is discarded.
- Normal path:
  - Significands mA = {1, fA}, mB = {1, fB}, each 8 bits.
  - Restoring division: remainder starts at mA. Each cycle: if rem ≥ mB, set q bit and rem −= mB; then rem <<= 1. Remainder is 9 bits wide.
  - q is in (0.5, 2). Biased exponent = eA − eB + 127 (10-bit signed).
  - If q[9]=0: shift q left 1 and decrement the exponent.
  - Round to nearest even using guard and sticky (sticky = |remaining q bits | (rem≠0)).
  - Mantissa carry-out on rounding increments the exponent.
- Overflow: final exponent ≥ 255 → signed inf.
- Underflow: final exponent ≤ 0 → signed zero (no denormal output).

Decomposition:
- Package bf16_pkg holds:
  - widths EXP_W=8, FRAC_W=7, EXP_BIAS=127
  - constants QNAN=16'h7FC0 and POS_INF=16'h7F80
  - state encoding: IDLE, DIV, ROUND, DONE
- Sub-module bf16_classify (combinational): 16-bit operand in; is_zero, is_inf, is_nan, sign, exponent, significand out. Instantiated twice, shared with future FPU blocks.

Test Plan:
- A=16'h4040 (3.0), B=16'h4000 (2.0), start pulse → done exactly 11 cycles after the accepting edge, C=16'h3FC0; busy high for cycles 1–11.
- A=16'h3F80, B=16'h4040 (1/3) → C=16'h3EAB (round up, sticky set). A=16'h40C0, B=16'hC000 → C=16'hC040.
- Specials: A=16'h3F80, B=16'h0000 → 16'h7F80; A=0, B=0 → 16'h7FC0; A=16'h7F80, B=16'h7F80 → 16'h7FC0; A=16'h0000, B=16'hBF80 → 16'h8000; all with latency 11.
- Range limits: A=16'h7F7F, B=16'h3F00 → 16'h7F80 (overflow); A=16'h0080, B=16'h4000 → 16'h0000 (underflow to zero).
- Handshake:
  - start held high continuously → results for successive operands with done every 12 cycles.
  - start pulsed while busy → ignored; C unchanged.
- Reset: rst asserted at cycle 5 of a division → busy=0, done=0, C=0 immediately; no done pulse follows. A new start after reset release gives the correct result.
